// File: rtl/uart_pkg.sv
// uart_pkg: shared state type, frame constants and round-robin pick for the UART scheduler
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
  localparam int UART_DATA_W = 8;
  localparam int UART_FRAME_BITS = 10;
  // First set bit of valid searching upward from last+1, wrapping at n; returns last if none set
  function automatic logic [2:0] rr_next(input logic [7:0] valid, input logic [2:0] last, input logic [3:0] n);
    logic found;
    logic [3:0] idx;
    found = 1'b0;
    rr_next = last;
    for (int i = 1; i <= 8; i++) begin
      idx = {1'b0, last} + 4'(i);
      if (idx >= n) idx = idx - n;
      if (!found && 4'(i) <= n && valid[idx[2:0]]) begin
        found = 1'b1;
        rr_next = idx[2:0];
      end
    end
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-rate divider with synchronous restart and a tick on the last cycle of each bit
module uart_baud_gen #(
  parameter int CLK_DIV = 28,
  localparam int CW = $clog2(CLK_DIV)
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == CW'(CLK_DIV - 1);
  assign cnt_d = restart || tick ? '0 : cnt_q + CW'(1);
  // Free-running divider, realigned to zero whenever a frame starts
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter feeding an 8N1 serializer that drives one shared TX line
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 28,
  parameter int NREQ = 2,
  localparam int GW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic            clk_in,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0] req_ready,
  output logic            tx,
  output logic            busy,
  output logic [GW-1:0]   grant_id
);
  uart_state_e state_q;
  logic [UART_DATA_W-1:0] shift_q;
  logic [2:0] bit_q;
  logic [GW-1:0] last_q;
  logic [2:0] win;
  logic [7:0] valid_pad;
  logic [7:0] bytes [8];
  logic start, tick;
  for (genvar g = 0; g < 8; g++) begin : g_bytes
    if (g < NREQ) begin : g_used
      assign bytes[g] = req_data[8*g +: 8];
    end else begin : g_pad
      assign bytes[g] = '0;
    end
  end
  assign valid_pad = 8'(req_valid);
  assign win = rr_next(valid_pad, 3'(last_q), 4'(NREQ));
  assign start = state_q == IDLE && |req_valid;
  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .restart(start),
    .tick(tick)
  );
  // Arbitration and serializer; every output is a register so tx cannot glitch
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q <= '0;
      last_q <= GW'(NREQ - 1);
      tx <= 1'b1;
      busy <= 1'b0;
      req_ready <= '0;
      grant_id <= '0;
    end else begin
      req_ready <= '0;
      case (state_q)
        IDLE: if (|req_valid) begin
          shift_q <= bytes[win];
          last_q <= GW'(win);
          grant_id <= GW'(win);
          req_ready <= NREQ'(1) << win;
          tx <= 1'b0;
          busy <= 1'b1;
          bit_q <= '0;
          state_q <= START;
        end
        START: if (tick) begin
          tx <= shift_q[0];
          shift_q <= shift_q >> 1;
          state_q <= DATA;
        end
        DATA: if (tick) begin
          if (bit_q == 3'd7) begin
            tx <= 1'b1;
            state_q <= STOP;
          end else begin
            tx <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_q <= bit_q + 3'd1;
          end
        end
        STOP: if (tick) begin
          busy <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: scenario tasks plus a randomized round-robin model checking two scheduler configurations
module tb_uart_tx_sched;
  import uart_pkg::*;
  localparam int CD0 = 4;
  localparam int CD1 = 2;
  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;
  logic rst_n0, rst_n1;
  logic [1:0] v0, rdy0;
  logic [15:0] d0;
  logic tx0, busy0;
  logic [0:0] gid0;
  logic [2:0] v1, rdy1;
  logic [23:0] d1;
  logic tx1, busy1;
  logic [1:0] gid1;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last0 = 1;
  always @(posedge clk_in) cyc <= cyc + 1;

  uart_tx_sched #(.CLK_DIV(CD0), .NREQ(2)) u_dut0 (
    .clk_in(clk_in), .rst_n(rst_n0), .req_valid(v0), .req_data(d0),
    .req_ready(rdy0), .tx(tx0), .busy(busy0), .grant_id(gid0)
  );
  uart_tx_sched #(.CLK_DIV(CD1), .NREQ(3)) u_dut1 (
    .clk_in(clk_in), .rst_n(rst_n1), .req_valid(v1), .req_data(d1),
    .req_ready(rdy1), .tx(tx1), .busy(busy1), .grant_id(gid1)
  );

  function automatic logic [2:0] rdy_of(input int d);
    return d != 0 ? rdy1 : {1'b0, rdy0};
  endfunction
  function automatic logic [1:0] gid_of(input int d);
    return d != 0 ? gid1 : {1'b0, gid0};
  endfunction
  function automatic logic tx_of(input int d);
    return d != 0 ? tx1 : tx0;
  endfunction
  function automatic logic busy_of(input int d);
    return d != 0 ? busy1 : busy0;
  endfunction

  task automatic check_frame(input int d, input logic [7:0] b, input int who, input int cd,
                             input bit drop, input bit mid_en, input logic [2:0] mid, output int st);
    logic [9:0] fr;
    logic [2:0] er;
    logic et, eb;
    int n;
    fr = {1'b1, b, 1'b0};
    n = 0;
    st = cyc;
    @(negedge clk_in);
    while (rdy_of(d) == 3'b000 && n < 30 * cd) begin
      @(negedge clk_in);
      n++;
    end
    vectors++;
    if (rdy_of(d) !== 3'(1 << who)) begin
      miscompares++;
      $display("FAIL ack d%0d: got req_ready=%b, want %b", d, rdy_of(d), 3'(1 << who));
      return;
    end
    vectors++;
    if (gid_of(d) !== 2'(who)) begin
      miscompares++;
      $display("FAIL grant_id d%0d: got %0d, want %0d", d, gid_of(d), who);
    end
    st = cyc;
    if (drop) begin
      if (d != 0) v1[who] = 1'b0;
      else v0[who] = 1'b0;
    end
    for (int k = 0; k <= UART_FRAME_BITS * cd; k++) begin
      if (k > 0) @(negedge clk_in);
      if (mid_en && k == 5 * cd) begin
        if (d != 0) v1 = mid;
        else v0 = mid[1:0];
      end
      et = k < UART_FRAME_BITS * cd ? fr[k / cd] : 1'b1;
      eb = k < UART_FRAME_BITS * cd;
      er = k == 0 ? 3'(1 << who) : 3'b000;
      vectors++;
      if ({tx_of(d), busy_of(d), rdy_of(d)} !== {et, eb, er}) begin
        miscompares++;
        $display("FAIL frame d%0d byte=%h k=%0d: got tx=%b busy=%b rdy=%b, want tx=%b busy=%b rdy=%b",
                 d, b, k, tx_of(d), busy_of(d), rdy_of(d), et, eb, er);
      end
    end
  endtask

  task automatic test_reset;
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    v0 = '0; v1 = '0; d0 = '0; d1 = '0;
    repeat (3) @(negedge clk_in);
    rst_n0 = 1'b1; rst_n1 = 1'b1;
    last0 = 1;
    repeat (100) begin
      @(negedge clk_in);
      vectors++;
      if ({tx0, busy0, rdy0, gid0, tx1, busy1, rdy1, gid1} !== 12'b1000_0100_0000) begin
        miscompares++;
        $display("FAIL reset_idle: got d0 tx=%b busy=%b rdy=%b gid=%0d d1 tx=%b busy=%b rdy=%b gid=%0d",
                 tx0, busy0, rdy0, gid0, tx1, busy1, rdy1, gid1);
      end
    end
    #2 rst_n0 = 1'b0;
    #1 vectors++;
    if ({tx0, busy0, rdy0, gid0} !== 5'b10000) begin
      miscompares++;
      $display("FAIL async_reset: got tx=%b busy=%b rdy=%b gid=%0d, want 1 0 00 0", tx0, busy0, rdy0, gid0);
    end
    @(negedge clk_in);
    rst_n0 = 1'b1;
    last0 = 1;
    @(negedge clk_in);
  endtask

  task automatic test_single;
    int st;
    d0[7:0] = 8'hA5;
    v0 = 2'b01;
    check_frame(0, 8'hA5, 0, CD0, 1'b1, 1'b0, 3'b000, st);
    last0 = 0;
  endtask

  task automatic test_back_to_back;
    int st, prev, who;
    d0 = {8'h22, 8'h11};
    v0 = 2'b11;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      who = (last0 + 1) % 2;
      check_frame(0, who != 0 ? 8'h22 : 8'h11, who, CD0, 1'b0, 1'b0, 3'b000, st);
      last0 = who;
      if (i > 0) begin
        vectors++;
        if (st - prev != UART_FRAME_BITS * CD0 + 1) begin
          miscompares++;
          $display("FAIL spacing: got %0d cycles, want %0d", st - prev, UART_FRAME_BITS * CD0 + 1);
        end
      end
      prev = st;
    end
    v0 = '0;
  endtask

  task automatic test_req1_first;
    int st;
    rst_n0 = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_n0 = 1'b1;
    last0 = 1;
    d0[15:8] = 8'($urandom);
    v0 = 2'b10;
    check_frame(0, d0[15:8], 1, CD0, 1'b1, 1'b0, 3'b000, st);
    last0 = 1;
    d0 = 16'($urandom);
    v0 = 2'b11;
    check_frame(0, d0[7:0], 0, CD0, 1'b1, 1'b0, 3'b000, st);
    check_frame(0, d0[15:8], 1, CD0, 1'b1, 1'b0, 3'b000, st);
    v0 = '0;
  endtask

  task automatic test_midframe_reset;
    int st, n;
    d0[7:0] = 8'h56;
    v0 = 2'b01;
    n = 0;
    @(negedge clk_in);
    while (rdy0 == 2'b00 && n < 30 * CD0) begin
      @(negedge clk_in);
      n++;
    end
    repeat (4 * CD0) @(negedge clk_in);
    vectors++;
    if ({tx0, busy0} !== 2'b01) begin
      miscompares++;
      $display("FAIL data_bit3: got tx=%b busy=%b, want tx=0 busy=1", tx0, busy0);
    end
    #2 rst_n0 = 1'b0;
    #1 vectors++;
    if ({tx0, busy0, rdy0} !== 4'b1000) begin
      miscompares++;
      $display("FAIL midframe_reset: got tx=%b busy=%b rdy=%b, want tx=1 busy=0 rdy=00", tx0, busy0, rdy0);
    end
    @(negedge clk_in);
    rst_n0 = 1'b1;
    last0 = 1;
    check_frame(0, 8'h56, 0, CD0, 1'b1, 1'b0, 3'b000, st);
    last0 = 0;
  endtask

  task automatic test_drop_nreq3;
    int st;
    d1 = {8'h00, 8'h77, 8'h3C};
    v1 = 3'b011;
    check_frame(1, 8'h3C, 0, CD1, 1'b1, 1'b1, 3'b100, st);
    check_frame(1, 8'h00, 2, CD1, 1'b1, 1'b0, 3'b000, st);
    repeat (20) begin
      @(negedge clk_in);
      vectors++;
      if ({tx1, busy1, rdy1} !== 5'b10000) begin
        miscompares++;
        $display("FAIL drop_idle: got tx=%b busy=%b rdy=%b, want tx=1 busy=0 rdy=000", tx1, busy1, rdy1);
      end
    end
  endtask

  task automatic test_random;
    logic [1:0] pv, add;
    int st, who, idx;
    pv = '0;
    for (int f = 0; f < 8; f++) begin
      add = 2'($urandom_range(0, 3));
      if ((pv | add) == 2'b00) add = 2'b01;
      for (int i = 0; i < 2; i++)
        if (add[i] && !pv[i]) d0[8*i +: 8] = 8'($urandom);
      pv = pv | add;
      v0 = pv;
      who = -1;
      for (int j = 1; j <= 2; j++) begin
        idx = (last0 + j) % 2;
        if (who < 0 && pv[idx]) who = idx;
      end
      check_frame(0, d0[8*who +: 8], who, CD0, 1'b1, 1'b0, 3'b000, st);
      pv[who] = 1'b0;
      last0 = who;
    end
    v0 = '0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_req1_first;
    test_midframe_reset;
    test_drop_nreq3;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
